// File: rtl/ioh_cpu_requester_if.sv
// ----------------------------------------------------------------------------
// ioh_cpu_requester_if
// Bundles the CPU command/response handshake and the IOhandler slot signals
// of one ioh_cpu_requester instance.
//   master : the requester itself (accepts CPU commands, drives the slot)
//   slave  : the environment (CPU core plus IOhandler slot)
// Signals:
//   cpu_valid/cpu_we/cpu_addr/cpu_wdata : command offered by the CPU
//   cpu_ready                           : FIFO not full
//   cpu_rdata/cpu_rvalid/cpu_wdone      : completion reporting to the CPU
//   writeRequest/readRequest/ADDR/DATA  : request towards the IOhandler slot
//   requestDone/DataToCPUs              : slot completion and shared read bus
//   busy/timeout                        : status
// ----------------------------------------------------------------------------
interface ioh_cpu_requester_if;
  logic        cpu_valid;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        cpu_wdone;
  logic        writeRequest;
  logic        readRequest;
  logic [15:0] ADDR;
  logic [15:0] DATA;
  logic        requestDone;
  logic [15:0] DataToCPUs;
  logic        busy;
  logic        timeout;

  modport master (
    input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, requestDone, DataToCPUs,
    output cpu_ready, cpu_rdata, cpu_rvalid, cpu_wdone,
           writeRequest, readRequest, ADDR, DATA, busy, timeout
  );

  modport slave (
    output cpu_valid, cpu_we, cpu_addr, cpu_wdata, requestDone, DataToCPUs,
    input  cpu_ready, cpu_rdata, cpu_rvalid, cpu_wdone,
           writeRequest, readRequest, ADDR, DATA, busy, timeout
  );
endinterface

// File: rtl/ioh_cpu_requester.sv
// ----------------------------------------------------------------------------
// ioh_cpu_requester
// CPU-side initiator for one IOhandler request slot. CPU commands are queued
// in a DEPTH-entry FIFO, then issued one at a time on writeRequest or
// readRequest with ADDR/DATA held stable until the slot's requestDone. Read
// data is captured from the shared DataToCPUs bus on completion.
// Ports:
//   Clk   : system clock, all state on the rising edge
//   reset : synchronous, active-high
//   bus   : ioh_cpu_requester_if.master (CPU handshake + IOhandler slot)
// Parameters:
//   DEPTH   : FIFO entries, power of two, >= 2
//   TIMEOUT : REQ cycles before the sticky timeout flag sets, 0 disables
// ----------------------------------------------------------------------------
module ioh_cpu_requester #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input logic                 Clk,
  input logic                 reset,
  ioh_cpu_requester_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and bookkeeping
  logic [DEPTH-1:0] mem_we_q, mem_we_d;
  logic [15:0]      mem_addr_q  [DEPTH];
  logic [15:0]      mem_addr_d  [DEPTH];
  logic [15:0]      mem_wdata_q [DEPTH];
  logic [15:0]      mem_wdata_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Command currently being issued and registered outputs
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          wdone_q, wdone_d;
  logic          wreq_q, wreq_d;
  logic          rreq_q, rreq_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] tcnt_q, tcnt_d;

  logic ready;
  logic push;
  logic pop;
  logic complete;

  assign ready    = (cnt_q != FULL_CNT);
  assign push     = bus.cpu_valid & ready;
  // Only IDLE drains the FIFO, so a command never skips the queue.
  assign pop      = (state_q == ST_IDLE) & (cnt_q != {CW{1'b0}});
  // requestDone counts only while a request is outstanding; the trailing
  // level seen in RELEASE (and any stray pulse in IDLE) is ignored.
  assign complete = (state_q == ST_REQ) & bus.requestDone;

  // FIFO write, pointer and occupancy update
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    if (push) begin
      mem_we_d[wr_ptr_q]    = bus.cpu_we;
      mem_addr_d[wr_ptr_q]  = bus.cpu_addr;
      mem_wdata_d[wr_ptr_q] = bus.cpu_wdata;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus.requestDone) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RELEASE: begin
        if (bus.requestDone) begin
          state_d = ST_RELEASE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: command capture, request bits, completion and status
  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      we_d   = mem_we_q[rd_ptr_q];
      addr_d = mem_addr_q[rd_ptr_q];
      data_d = mem_wdata_q[rd_ptr_q];
    end else begin
      we_d   = we_q;
    end

    // Request bits are derived from the next state so they are flops that
    // rise together with the REQ state and fall on the completion edge.
    wreq_d = (state_d == ST_REQ) &  we_d;
    rreq_d = (state_d == ST_REQ) & ~we_d;

    wdone_d  = complete &  we_q;
    rvalid_d = complete & ~we_q;
    if (complete & ~we_q) begin
      rdata_d = bus.DataToCPUs;
    end else begin
      rdata_d = rdata_q;
    end

    // Timeout counter restarts on every REQ entry and saturates at the limit.
    tcnt_d = tcnt_q;
    if (pop) begin
      tcnt_d = {TW{1'b0}};
    end else if ((state_q == ST_REQ) && (tcnt_q != TO_LIMIT)) begin
      tcnt_d = tcnt_q + TW'(1);
    end else begin
      tcnt_d = tcnt_q;
    end
    if (TO_EN && (state_q == ST_REQ) && (tcnt_d == TO_LIMIT)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end

    busy_d = (cnt_d != {CW{1'b0}}) | (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mem_we_q  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_addr_q[i]  <= 16'h0000;
        mem_wdata_q[i] <= 16'h0000;
      end
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      we_q      <= 1'b0;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      rdata_q   <= 16'h0000;
      rvalid_q  <= 1'b0;
      wdone_q   <= 1'b0;
      wreq_q    <= 1'b0;
      rreq_q    <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= {TW{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      wdone_q     <= wdone_d;
      wreq_q      <= wreq_d;
      rreq_q      <= rreq_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      tcnt_q      <= tcnt_d;
    end
  end

  assign bus.cpu_ready    = ready;
  assign bus.cpu_rdata    = rdata_q;
  assign bus.cpu_rvalid   = rvalid_q;
  assign bus.cpu_wdone    = wdone_q;
  assign bus.writeRequest = wreq_q;
  assign bus.readRequest  = rreq_q;
  assign bus.ADDR         = addr_q;
  assign bus.DATA         = data_q;
  assign bus.busy         = busy_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_ioh_cpu_requester.sv
// ----------------------------------------------------------------------------
// tb_ioh_cpu_requester
// Self-checking bench for ioh_cpu_requester (DEPTH=4, TIMEOUT=8). Commands
// come from a vector table; each accepted command is pushed to a scoreboard
// queue and popped when the DUT issues it on the slot, where type, address,
// data, completion pulse and read data are compared.
// ----------------------------------------------------------------------------
module tb_ioh_cpu_requester;

  logic Clk;
  logic reset;

  ioh_cpu_requester_if bus ();

  ioh_cpu_requester #(
    .DEPTH   (4),
    .TIMEOUT (8)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // inputs: we/addr/wdata/resp/hold ; expected: request bits, cpu_rdata at completion
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] resp;
    int          hold;
    logic [1:0]  exp_req;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vec [12];
  vec_t pend;
  vec_t sb [$];
  int   total;
  int   bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge; a command offered with cpu_ready high
  // is taken on the rising edge in between and enters the scoreboard.
  task automatic tick();
    logic acc;
    acc = bus.cpu_valid & bus.cpu_ready;
    @(negedge Clk);
    if (acc) begin
      sb.push_back(pend);
      bus.cpu_valid = 1'b0;
    end
  endtask

  task automatic offer(input int i);
    pend          = vec[i];
    bus.cpu_valid = 1'b1;
    bus.cpu_we    = vec[i].we;
    bus.cpu_addr  = vec[i].addr;
    bus.cpu_wdata = vec[i].wdata;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.cpu_valid   = 1'b0;
    bus.requestDone = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  // Act as the IOhandler slot for the oldest scoreboard entry.
  task automatic serve();
    vec_t       e;
    int         n;
    logic [1:0] pulse_exp;
    n = 0;
    while (({bus.writeRequest, bus.readRequest} == 2'b00) && (n < 64)) begin
      tick();
      n++;
    end
    if ((n >= 64) || (sb.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL serve_wait: waited %0d cycles with %0d expected, want a request", n, sb.size());
      return;
    end
    e = sb.pop_front();
    check("serve_type", 32'({bus.writeRequest, bus.readRequest}), 32'(e.exp_req));
    check("serve_addr", 32'(bus.ADDR), 32'(e.addr));
    if (e.we) begin
      check("serve_data", 32'(bus.DATA), 32'(e.wdata));
    end
    pulse_exp       = e.we ? 2'b10 : 2'b01;
    bus.requestDone = 1'b1;
    bus.DataToCPUs  = e.resp;
    for (int h = 0; h < e.hold; h++) begin
      tick();
      if (h == 0) begin
        check("done_pulse", 32'({bus.cpu_wdone, bus.cpu_rvalid}), 32'(pulse_exp));
        check("done_rdata", 32'(bus.cpu_rdata), 32'(e.exp_rdata));
      end else begin
        check("done_single_pulse", 32'({bus.cpu_wdone, bus.cpu_rvalid}), 32'(0));
      end
      check("done_req_drop", 32'({bus.writeRequest, bus.readRequest}), 32'(0));
      if (h == e.hold - 1) begin
        bus.requestDone = 1'b0;
        bus.DataToCPUs  = 16'hDEAD;
      end
    end
    tick();
    check("release_req_low", 32'({bus.writeRequest, bus.readRequest}), 32'(0));
    check("release_no_pulse", 32'({bus.cpu_wdone, bus.cpu_rvalid}), 32'(0));
    check("rdata_hold", 32'(bus.cpu_rdata), 32'(e.exp_rdata));
    tick();
    check("next_req_spacing", 32'((bus.writeRequest | bus.readRequest) ? 1 : 0),
          32'((sb.size() != 0) ? 1 : 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int reqs;
    total = 0;
    bad   = 0;
    reset           = 1'b1;
    bus.cpu_valid   = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = 16'h0000;
    bus.cpu_wdata   = 16'h0000;
    bus.requestDone = 1'b0;
    bus.DataToCPUs  = 16'h0000;

    //               we    addr      wdata     resp      hold exp_req exp_rdata
    vec[0]  = '{1'b1, 16'h0010, 16'h1234, 16'hFFFF, 1, 2'b10, 16'h0000};
    vec[1]  = '{1'b0, 16'h0020, 16'h0000, 16'hBEEF, 1, 2'b01, 16'hBEEF};
    vec[2]  = '{1'b1, 16'h0100, 16'hA001, 16'h1111, 1, 2'b10, 16'hBEEF};
    vec[3]  = '{1'b0, 16'h0101, 16'hA002, 16'h1357, 1, 2'b01, 16'h1357};
    vec[4]  = '{1'b1, 16'h0102, 16'hA003, 16'h2222, 3, 2'b10, 16'h1357};
    vec[5]  = '{1'b0, 16'h0103, 16'hA004, 16'h2468, 3, 2'b01, 16'h2468};
    vec[6]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h8001, 2, 2'b01, 16'h8001};
    vec[7]  = '{1'b1, 16'h0000, 16'hFFFF, 16'h3333, 1, 2'b10, 16'h8001};
    vec[8]  = '{1'b0, 16'h0040, 16'h5555, 16'h5A5A, 1, 2'b01, 16'h5A5A};
    vec[9]  = '{1'b1, 16'h0200, 16'h0001, 16'h0000, 1, 2'b10, 16'h5A5A};
    vec[10] = '{1'b1, 16'h0201, 16'h0002, 16'h0000, 1, 2'b10, 16'h5A5A};
    vec[11] = '{1'b1, 16'h0202, 16'h0003, 16'h0000, 1, 2'b10, 16'h5A5A};

    @(negedge Clk);
    do_reset();

    // reset values
    check("rst_req",     32'({bus.writeRequest, bus.readRequest}), 32'(0));
    check("rst_pulses",  32'({bus.cpu_wdone, bus.cpu_rvalid}), 32'(0));
    check("rst_busy",    32'(bus.busy), 32'(0));
    check("rst_timeout", 32'(bus.timeout), 32'(0));
    check("rst_addr",    32'(bus.ADDR), 32'(0));
    check("rst_data",    32'(bus.DATA), 32'(0));
    check("rst_rdata",   32'(bus.cpu_rdata), 32'(0));
    check("rst_ready",   32'(bus.cpu_ready), 32'(1));

    // single write: request visible exactly two cycles after the push edge
    offer(0);
    tick();
    check("wr_t1_req",  32'({bus.writeRequest, bus.readRequest}), 32'(0));
    check("wr_t1_busy", 32'(bus.busy), 32'(1));
    tick();
    check("wr_t2_req",  32'({bus.writeRequest, bus.readRequest}), 32'(2'b10));
    serve();

    // single read returning 0xBEEF
    offer(1);
    tick();
    tick();
    check("rd_t2_req", 32'({bus.writeRequest, bus.readRequest}), 32'(2'b01));
    serve();

    // fill: one in REQ, four queued, sixth command refused until a completion
    for (int i = 2; i <= 6; i++) begin
      offer(i);
      tick();
    end
    check("fill_ready_low", 32'(bus.cpu_ready), 32'(0));
    check("fill_req_high",  32'((bus.writeRequest | bus.readRequest) ? 1 : 0), 32'(1));
    offer(7);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fill_blocked", 32'(bus.cpu_ready), 32'(0));
    end
    for (int k = 0; k < 6; k++) begin
      serve();
    end
    check("fill_all_done", 32'(sb.size()), 32'(0));
    check("fill_idle_busy", 32'(bus.busy), 32'(0));

    // timeout after 8 REQ cycles, request held, sticky across completion
    do_reset();
    offer(8);
    tick();
    tick();
    check("to_req_start", 32'({bus.writeRequest, bus.readRequest}), 32'(2'b01));
    for (int k = 0; k < 7; k++) begin
      tick();
    end
    check("to_before_limit", 32'(bus.timeout), 32'(0));
    tick();
    check("to_set",        32'(bus.timeout), 32'(1));
    check("to_req_held",   32'({bus.writeRequest, bus.readRequest}), 32'(2'b01));
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    check("to_sticky",     32'(bus.timeout), 32'(1));
    check("to_req_still",  32'({bus.writeRequest, bus.readRequest}), 32'(2'b01));
    serve();
    check("to_after_done", 32'(bus.timeout), 32'(1));

    // reset during REQ with two commands queued
    offer(9);
    tick();
    offer(10);
    tick();
    offer(11);
    tick();
    check("mid_req_high", 32'({bus.writeRequest, bus.readRequest}), 32'(2'b10));
    check("mid_full_q",   32'(bus.busy), 32'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    check("mid_rst_req",     32'({bus.writeRequest, bus.readRequest}), 32'(0));
    check("mid_rst_ready",   32'(bus.cpu_ready), 32'(1));
    check("mid_rst_busy",    32'(bus.busy), 32'(0));
    check("mid_rst_timeout", 32'(bus.timeout), 32'(0));
    pulses = 0;
    reqs   = 0;
    for (int k = 0; k < 20; k++) begin
      bus.requestDone = k[0];
      tick();
      if (bus.cpu_wdone | bus.cpu_rvalid) pulses++;
      if (bus.writeRequest | bus.readRequest | bus.busy) reqs++;
    end
    bus.requestDone = 1'b0;
    check("mid_no_pulses",   32'(pulses), 32'(0));
    check("mid_no_requests", 32'(reqs), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ioh_cpu_requester.md
# ioh_cpu_requester

CPU-side initiator for one of the five IOhandler request slots. It accepts read/write commands from a CPU core into a small FIFO and presents them one at a time on its writeRequest/readRequest bit with stable ADDRn/DATAn. It then waits for that slot's requestDone and returns read data taken from the shared DataToCPUs bus. One instance is placed per CPU, between the core and the IOhandler arbiter.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥2
- TIMEOUT, 1024, cycles in REQ before timeout flag sets; 0 disables

- Clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_valid  in  1  command offered
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  16  command address
- cpu_wdata  in  16  write data (ignored for reads)
- cpu_ready  out  1  FIFO not full; command accepted when cpu_valid & cpu_ready
- cpu_rdata  out  16  read result, valid while cpu_rvalid
- cpu_rvalid  out  1  one-cycle pulse per completed read
- cpu_wdone  out  1  one-cycle pulse per completed write
- writeRequest  out  1  to this slot's IOhandler writeRequest bit
- readRequest  out  1  to this slot's IOhandler readRequest bit
- ADDR  out  16  to IOhandler ADDRn
- DATA  out  16  to IOhandler DATAn
- requestDone  in  1  this slot's IOhandler requestDone bit
- DataToCPUs  in  16  shared read-data bus from IOhandler
- busy  out  1  FIFO non-empty or state ≠ IDLE
- timeout  out  1  sticky; cleared only by reset

## Operation
- FIFO: each entry holds {we, addr, wdata}. Push on cpu_valid & cpu_ready. cpu_ready = !full, combinational from the count. There is no bypass: a command always passes through the FIFO. Count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- A push and a pop in the same cycle are both honoured, and the count is unchanged.
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: if the FIFO is non-empty, pop the head into the ADDR/DATA/we registers and go to REQ. If empty, stay.
  - REQ: writeRequest = we, readRequest = !we. ADDR and DATA are held constant. When requestDone = 1, do the following on that edge:
    - read: cpu_rdata ← DataToCPUs, and cpu_rvalid pulses.
    - write: cpu_wdone pulses.
    - Drop both request bits and go to RELEASE.
  - RELEASE: request bits are 0. When requestDone = 0, go to IDLE.
- Exactly one request bit is high in REQ. Both request bits are 0 in IDLE and RELEASE.
- DATA keeps its last value outside REQ. For reads, DATA is don't-care and holds the popped wdata.
- Timeout counter: cleared on entry to REQ and increments each REQ cycle. When TIMEOUT ≠ 0 and the count reaches TIMEOUT, timeout ← 1 and the counter saturates. The request stays asserted and is never abandoned.
- A requestDone seen in IDLE or RELEASE (other than the trailing level) is ignored.

## Timing
- Reset values: writeRequest, readRequest, cpu_rvalid, cpu_wdone, busy, timeout = 0. ADDR, DATA, cpu_rdata = 0x0000. cpu_ready = 1. FIFO empty. State is IDLE.
- Reset in any state, including mid-REQ: request bits are 0 on the next cycle and queued commands are discarded.
- Latency, with the push accepted at edge t:
  - FIFO visible in cycle t+1.
  - IDLE pops at edge t+1.
  - Request bit high from cycle t+2.
- Completion, with requestDone first high in cycle d:
  - Request bit low in cycle d+1.
  - cpu_rvalid/cpu_wdone high in cycle d+1 only.
  - cpu_rdata holds until the next read completes.
- If requestDone stays high N cycles, the block stays in RELEASE until it drops. Exactly one completion is produced.
- Minimum spacing between successive requests is 2 cycles after requestDone falls: RELEASE→IDLE, then IDLE→REQ.
- busy is registered and reflects the state and count after each edge.

## Test plan
- Single write: push we=1, addr 0x0010, wdata 0x1234 at t. → writeRequest=1, ADDR=0x0010, DATA=0x1234 from t+2. Drive requestDone high 1 cycle at d. → cpu_wdone pulse at d+1, writeRequest=0 at d+1.
- Single read: push we=0, addr 0x0020. Respond with requestDone plus DataToCPUs=0xBEEF. → cpu_rdata=0xBEEF, cpu_rvalid one cycle, readRequest never overlaps writeRequest.
- Fill/back-pressure (DEPTH=4): push 5 commands with requestDone held 0. → 1st popped into REQ, 4 queued. The next push is refused (cpu_ready=0) until the first completes. Completions occur in push order, and addresses match.
- Long done: hold requestDone high 3 cycles. → one completion pulse only. The next request is asserted only after requestDone returns to 0 plus 1 cycle.
- Timeout (TIMEOUT=8): never assert requestDone. → timeout=1 after 8 REQ cycles, request stays high. A later requestDone completes normally and timeout stays 1.
- Reset mid-operation: assert reset during REQ with 2 queued. → next cycle: request bits 0, cpu_ready=1, busy=0, timeout=0. No completion pulses afterwards.
